// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, false-start and framing checks.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_param_check
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

`ifdef UART_RX_PARITY_EN
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction
`endif

  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_flag_q, par_flag_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign rx_s = sync2_q;

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flag_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_flag_q   <= par_flag_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and output pulse decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flag_d   = par_flag_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          bit_d   = '0;
          state_d = S_START;
`ifdef UART_RX_PARITY_EN
          par_flag_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == WORD_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          par_flag_d = rx_s ^ parity_bit(shift_q, PARITY_ODD != 0);
          state_d    = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        // Leave on the mid-stop sample so the next start edge gets half a bit of slack
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_flag_q;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver that deserialises an asynchronous `rx` line into parallel words. It replaces the fixed 8-bit, fixed-ratio receiver in the serial front end.
- Adds:
  - configurable oversampling ratio and word width;
  - an input synchroniser, mid-bit sampling and false-start rejection;
  - stop-bit framing check and optional parity check.
- Delivers each word with a one-cycle `valid` pulse to the downstream consumer.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per UART bit; legal range ≥ 4. Half-bit `H = CLKS_PER_BIT/2` (integer division).
- `DATA_BITS`, 8: data bits per frame, LSB first; legal range 5..9.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when `UART_RX_PARITY_EN` is defined.
- `clk` input 1: clock.
- `rst` input 1: reset; synchronous, active-high.
- `rx` input 1: asynchronous serial line; idles high.
- `data` output DATA_BITS: last correctly framed word; holds until the next good frame.
- `valid` output 1: one-cycle pulse; `data` is updated on the same edge.
- `frame_err` output 1: one-cycle pulse; stop bit sampled low.
- `parity_err` output 1: one-cycle pulse; parity mismatch (macro only).
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **Synchroniser:** two flops on `rx`, producing `rx_s`; both flops reset to 1. All decisions use `rx_s` only.
- **IDLE:** if `rx_s == 0`, clear the cycle counter and bit counter, then go to START.
- **START:** count to H. Sample `rx_s` at H:
  - `rx_s == 1`: false start; return to IDLE with no output pulse.
  - `rx_s == 0`: go to DATA with the counter cleared.
- **DATA:** sample every `CLKS_PER_BIT` cycles. Shift the sample into the MSB of a DATA_BITS shift register, shifting right, so the first bit ends up in the LSB. After DATA_BITS samples, go to PARITY (macro on) or STOP.
- **PARITY:** sample one bit after `CLKS_PER_BIT` cycles. Compare it against the XOR of the data bits, with the XOR inverted when `PARITY_ODD = 1`. Latch the mismatch flag, then go to STOP.
- **STOP:** sample after `CLKS_PER_BIT` cycles.
  - `rx_s == 1`: load `data` from the shift register, pulse `valid`, pulse `parity_err` if the latched flag is set, and go directly to IDLE. The receiver does not wait out the second half of the stop bit, which gives half a bit of resync slack.
  - `rx_s == 0`: pulse `frame_err`; `data`, `valid` and `parity_err` stay unchanged or low. Go to BREAK.
- **BREAK:** wait for `rx_s == 1`, then go to IDLE. A line held low never generates repeated frames.
- **Counter width:** `$clog2(CLKS_PER_BIT)` bits; wraps to 0 on every sample.
- **Bit counter width:** `$clog2(DATA_BITS+1)` bits.
- **Simultaneous events:** `frame_err` takes precedence; `parity_err` and `valid` are 0 in a frame-error cycle.
- **Reset mid-frame:** state returns to IDLE; counters and shift register clear; synchroniser flops go to 1. No pulses are generated.

## Timing
- **Reset values:** `data = 0`, `valid = 0`, `frame_err = 0`, `parity_err = 0`, `busy = 0`.
- **Synchroniser latency:** 2 cycles from the `rx` pin to `rx_s`.
- **Reference edge T0:** the edge at which IDLE sees `rx_s == 0`. `busy` is high from T0+1.
- **Sample edges:**
  - start bit at T0+H;
  - data bit k (k = 0..DATA_BITS-1) at T0 + H + (k+1)·CLKS_PER_BIT;
  - parity bit at T0 + H + (DATA_BITS+1)·CLKS_PER_BIT;
  - stop bit at T0 + H + (DATA_BITS+1+P)·CLKS_PER_BIT, where P = 1 with parity, else 0.
- **Outputs:** all output pulses are registered at the stop-sample edge and are high for exactly the following cycle. `busy` falls in that same cycle.
- **Back-to-back frames:** a new start may be detected on the very next edge after the stop sample.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - PARITY state present; the frame carries one parity bit between data and stop.
  - `parity_err` is functional, and `PARITY_ODD` selects the sense.
- **`UART_RX_PARITY_EN` undefined:**
  - no PARITY state; the frame is start + DATA_BITS + stop.
  - `parity_err` is tied to 0, and `PARITY_ODD` is ignored.

## Test plan
All scenarios use `CLKS_PER_BIT = 16` and `DATA_BITS = 8`.
- **Good frame:** send 0xA5 at 16 clk/bit, no parity → `data = 0xA5`; `valid` high for exactly 1 cycle at T0 + 8 + 9·16 + 1; `frame_err = 0`.
- **False start:** drive `rx` low for 4 cycles, then high → no pulses; `busy` falls after T0+8; `data` is unchanged.
- **Framing error:** send 0x3C with stop bit = 0, hold `rx` low for 40 more cycles, then release → `frame_err` pulses once, `valid = 0`, `data` keeps its previous value. `busy` stays high until `rx_s` returns high, and no second frame is decoded.
- **Parity error:** with the macro on, even parity, send 0x07 with parity bit 0 (correct is 1) → `data = 0x07`, `valid = 1` and `parity_err = 1` in the same cycle. Repeat with parity bit 1 → `parity_err = 0`.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap, and with the stop bit shortened to 9 cycles → two `valid` pulses with data 0x00 then 0xFF.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 of 0x55 → all outputs 0, `busy = 0`; the next frame 0x81 is received correctly with no spurious pulse.
